// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receive path. It synchronizes the serial line and
//                samples each bit at mid-period. Bytes go into a show-ahead
//                FIFO that the datapath drains with a one-cycle read strobe.
//                Overrun and frame errors are held in sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_ADDR_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   UART_RX,
  input  logic                   UART_READ_EN,
  input  logic                   err_clr,
  output logic [31:0]            UART_READ_DATA,
  output logic                   rx_empty,
  output logic                   rx_full,
  output logic [FIFO_ADDR_W:0]   rx_count,
  output logic                   overrun,
  output logic                   frame_error
);

  localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int                 c_DEPTH = 1 << FIFO_ADDR_W;
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [1:0]           r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic [FIFO_ADDR_W:0] r_wr_ptr;
  logic [FIFO_ADDR_W:0] r_rd_ptr;
  logic [7:0]           r_mem [c_DEPTH];
  logic                 r_overrun;
  logic                 r_frame_error;

  logic w_stop_sample;
  logic w_push;
  logic w_pop;
  logic w_write;
  logic w_overrun_set;
  logic w_frame_set;
  logic w_empty;
  logic w_full;

  // FIFO status and stop-bit decisions
  always_comb begin
    w_empty       = (r_wr_ptr == r_rd_ptr);
    w_full        = (r_wr_ptr == {~r_rd_ptr[FIFO_ADDR_W], r_rd_ptr[FIFO_ADDR_W-1:0]});
    w_stop_sample = (r_state == c_STOP) && (r_cnt == c_LAST);
    w_push        = w_stop_sample && r_rx_s;
    w_frame_set   = w_stop_sample && !r_rx_s;
    w_pop         = UART_READ_EN && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte
    w_write       = w_push && (!w_full || w_pop);
    w_overrun_set = w_push && w_full && !w_pop;
  end

  // Two-stage synchronizer plus edge-detect history; idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= UART_RX;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  // Receive FSM: mid-bit sampling driven by a single period counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (r_rx_prev && !r_rx_s) begin
            r_cnt   <= '0;
            r_state <= c_START;
          end
        end
        c_START: begin
          if (r_cnt == c_HALF) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? c_IDLE : c_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_DATA: begin
          if (r_cnt == c_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            r_bit_idx          <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_state <= c_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == c_LAST) begin
            r_cnt   <= '0;
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO pointers with wrap bit and the sticky error flags (set beats clear)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_set) begin
        r_frame_error <= 1'b1;
      end else if (err_clr) begin
        r_frame_error <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr[FIFO_ADDR_W-1:0]] <= r_shift;
    end
  end

  // Show-ahead read port; all-ones marks an empty FIFO to software
  always_comb begin
    UART_READ_DATA = 32'hFFFF_FFFF;
    if (!w_empty) begin
      UART_READ_DATA = {24'b0, r_mem[r_rd_ptr[FIFO_ADDR_W-1:0]]};
    end
    rx_empty    = w_empty;
    rx_full     = w_full;
    rx_count    = r_wr_ptr - r_rd_ptr;
    overrun     = r_overrun;
    frame_error = r_frame_error;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Directed self-checking bench for uart_receiver at 16 clocks
//                per bit. It uses a vector table and hand-written corner
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int c_BIT = 16;

  logic        clk;
  logic        reset;
  logic        UART_RX;
  logic        UART_READ_EN;
  logic        err_clr;
  logic [31:0] UART_READ_DATA;
  logic        rx_empty;
  logic        rx_full;
  logic [4:0]  rx_count;
  logic        overrun;
  logic        frame_error;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        do_read;
    logic [4:0]  exp_count;
    logic [31:0] exp_head;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs [6];

  uart_receiver #(.CLKS_PER_BIT(c_BIT), .FIFO_ADDR_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .UART_RX        (UART_RX),
    .UART_READ_EN   (UART_READ_EN),
    .err_clr        (err_clr),
    .UART_READ_DATA (UART_READ_DATA),
    .rx_empty       (rx_empty),
    .rx_full        (rx_full),
    .rx_count       (rx_count),
    .overrun        (overrun),
    .frame_error    (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      UART_RX = 1'b1;
    end
  endtask

  // One 8N1 frame; rd_cyc selects a cycle in which the read strobe is raised
  task automatic send_byte(input logic [7:0] d, input logic stop, input int rd_cyc);
    int bn;
    for (int cyc = 0; cyc < 10 * c_BIT; cyc++) begin
      @(negedge clk);
      bn = cyc / c_BIT;
      if (bn == 0)      UART_RX = 1'b0;
      else if (bn == 9) UART_RX = stop;
      else              UART_RX = d[3'(bn - 1)];
      UART_READ_EN = (cyc == rd_cyc);
    end
    @(negedge clk);
    UART_READ_EN = 1'b0;
    if (!stop) idle(c_BIT);
  endtask

  task automatic read_one();
    @(negedge clk);
    UART_READ_EN = 1'b1;
    @(negedge clk);
    UART_READ_EN = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //           data   stop  read  count  head           ferr
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 5'd1, 32'h0000_00A5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 5'd1, 32'h0000_0011, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 5'd2, 32'h0000_0011, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 5'd2, 32'h0000_0080, 1'b1};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 5'd2, 32'h0000_0001, 1'b1};

    reset = 1'b0; UART_RX = 1'b1; UART_READ_EN = 1'b0; err_clr = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_data",  UART_READ_DATA, 32'hFFFF_FFFF);
    check("reset_empty", 32'(rx_empty), 32'd1);
    check("reset_full",  32'(rx_full), 32'd0);
    check("reset_count", 32'(rx_count), 32'd0);
    check("reset_ovr",   32'(overrun), 32'd0);
    check("reset_ferr",  32'(frame_error), 32'd0);
    reset = 1'b1;
    idle(5);

    // Table: back-to-back frames, checks after each, optional pop
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].data, vecs[i].stop, -1);
      check($sformatf("vec%0d_count", i), 32'(rx_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_head", i), UART_READ_DATA, vecs[i].exp_head);
      check($sformatf("vec%0d_ferr", i), 32'(frame_error), 32'(vecs[i].exp_ferr));
      if (vecs[i].do_read) read_one();
    end
    check("tbl_last_head", UART_READ_DATA, 32'h0000_005A);
    read_one();
    check("tbl_drain_empty", 32'(rx_empty), 32'd1);
    check("tbl_drain_data", UART_READ_DATA, 32'hFFFF_FFFF);
    read_one();
    check("read_empty_count", 32'(rx_count), 32'd0);

    // Break: one framing error, no retrigger while held low
    pulse_clr();
    check("clr_ferr", 32'(frame_error), 32'd0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      UART_RX = 1'b0;
    end
    idle(20);
    check("break_ferr", 32'(frame_error), 32'd1);
    check("break_count", 32'(rx_count), 32'd0);
    send_byte(8'h11, 1'b1, -1);
    check("after_break_count", 32'(rx_count), 32'd1);
    check("after_break_data", UART_READ_DATA, 32'h0000_0011);
    pulse_clr();
    check("ferr_cleared", 32'(frame_error), 32'd0);
    read_one();

    // Glitch shorter than half a bit is rejected
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      UART_RX = 1'b0;
    end
    idle(40);
    check("glitch_count", 32'(rx_count), 32'd0);
    check("glitch_ferr", 32'(frame_error), 32'd0);
    check("glitch_ovr", 32'(overrun), 32'd0);
    send_byte(8'h42, 1'b1, -1);
    check("post_glitch_data", UART_READ_DATA, 32'h0000_0042);
    read_one();

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, -1);
    check("ovr_full", 32'(rx_full), 32'd1);
    check("ovr_count", 32'(rx_count), 32'd16);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_rd%0d", i), UART_READ_DATA, 32'(i));
      read_one();
    end
    check("ovr_drained", 32'(rx_empty), 32'd1);
    pulse_clr();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Full FIFO plus a read on the push edge (stop sample at edge 155)
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1, -1);
    check("sim_pre_full", 32'(rx_full), 32'd1);
    send_byte(8'h77, 1'b1, 154);
    check("sim_count", 32'(rx_count), 32'd16);
    check("sim_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sim_rd%0d", i), UART_READ_DATA,
            (i == 15) ? 32'h77 : 32'h21 + 32'(i));
      read_one();
    end
    check("sim_empty", 32'(rx_empty), 32'd1);

    // Reset during data bit 4 aborts the partial byte
    for (int cyc = 0; cyc < 5 * c_BIT + 8; cyc++) begin
      @(negedge clk);
      UART_RX = (cyc < c_BIT) ? 1'b0 : ((cyc / c_BIT) % 2 == 1);
    end
    @(negedge clk);
    UART_RX = 1'b1;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(3 * c_BIT);
    check("rst_mid_count", 32'(rx_count), 32'd0);
    send_byte(8'h5A, 1'b1, -1);
    check("rst_mid_count2", 32'(rx_count), 32'd1);
    check("rst_mid_data", UART_READ_DATA, 32'h0000_005A);
    check("rst_mid_ferr", 32'(frame_error), 32'd0);
    read_one();
    check("rst_mid_empty", 32'(rx_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
